clk_div_multi: RTL and testbench

Multi-channel, runtime-programmable successor to the fixed single-output clock divider. Each of NUM_CH channels divides clk_in by its own divisor. Each channel outputs either a one-cycle enable strobe (pulse mode) or a near-50% square wave (square mode). Divisor and mode are reprogrammed through a shadow register and take effect glitch-free at the channel's next wrap. A global restart phase-aligns all channels. The block feeds strobes and enables to the compute and VGA timing logic.

---
 rtl/clk_div_multi.sv | 112 +++++++++++
 tb/tb_clk_div_multi.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with shadowed per-channel config.
// Each channel emits a wrap strobe plus a pulse or near-50% square output.
module clk_div_multi #(
  parameter int NUM_CH       = 4,
  parameter int DIV_W        = 16,
  parameter int DEFAULT_DIV  = 4,
  parameter int DEFAULT_MODE = 0,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  input  logic              sync_restart,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tc_out,
  output logic [NUM_CH-1:0] cfg_pending
);

  localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEFAULT_DIV);
  localparam logic             DEF_MODE = (DEFAULT_MODE != 0);
  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO      = DIV_W'(2);

  logic cfg_ok;
  assign cfg_ok = cfg_we && (32'(cfg_ch) < NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] act_div;
    logic [DIV_W-1:0] sh_div;
    logic [DIV_W-1:0] n;
    logic [DIV_W-1:0] half;
    logic             act_mode;
    logic             sh_mode;
    logic             pend;
    logic             co;
    logic             tc;
    logic             wr;
    logic             wrap;

    // Clamp at use time so a stored 0/1 still divides by 2.
    assign n    = (act_div < TWO) ? TWO : act_div;
    assign half = n >> 1;
    assign wrap = (cnt >= n - ONE);
    assign wr   = cfg_ok && (cfg_ch == CH_W'(i));

    always_ff @(posedge clk_in) begin
      if (!reset_n) begin
        cnt      <= '0;
        act_div  <= DEF_DIV;
        act_mode <= DEF_MODE;
        sh_div   <= DEF_DIV;
        sh_mode  <= DEF_MODE;
        pend     <= 1'b0;
        co       <= 1'b0;
        tc       <= 1'b0;
      end else begin
        if (sync_restart) begin
          cnt <= '0;
          co  <= 1'b0;
          tc  <= 1'b0;
          if (pend) begin
            act_div  <= sh_div;
            act_mode <= sh_mode;
            pend     <= 1'b0;
          end
        end else if (en[i]) begin
          if (wrap) begin
            cnt <= '0;
            tc  <= 1'b1;
            co  <= 1'b1;
            if (pend) begin
              act_div  <= sh_div;
              act_mode <= sh_mode;
              pend     <= 1'b0;
            end
          end else begin
            cnt <= cnt + ONE;
            tc  <= 1'b0;
            if (!act_mode || (cnt == half - ONE))
              co <= 1'b0;
          end
        end else begin
          tc <= 1'b0;
          if (!act_mode)
            co <= 1'b0;
          if (pend) begin
            act_div  <= sh_div;
            act_mode <= sh_mode;
            pend     <= 1'b0;
            cnt      <= '0;
          end
        end
        // A write in the apply cycle lands after the apply: it stays pending.
        if (wr) begin
          sh_div  <= cfg_div;
          sh_mode <= cfg_mode;
          pend    <= 1'b1;
        end
      end
    end

    assign clk_out[i]     = co;
    assign tc_out[i]      = tc;
    assign cfg_pending[i] = pend;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi.
// Steps are sampled 1 time unit after each rising edge of clk_in.
module tb_clk_div_multi;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic [3:0]  en;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        cfg_mode;
  logic        sync_restart;
  logic [3:0]  clk_out;
  logic [3:0]  tc_out;
  logic [3:0]  cfg_pending;

  int checks = 0;
  int errors = 0;

  clk_div_multi #(
    .NUM_CH(4),
    .DIV_W(16),
    .DEFAULT_DIV(4),
    .DEFAULT_MODE(0)
  ) dut (
    .clk_in(clk_in),
    .reset_n(reset_n),
    .en(en),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_mode(cfg_mode),
    .sync_restart(sync_restart),
    .clk_out(clk_out),
    .tc_out(tc_out),
    .cfg_pending(cfg_pending)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [15:0] d,
                    input logic m);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_div  = d;
    cfg_mode = m;
  endtask

  initial begin
    int w;
    reset_n      = 1'b0;
    en           = 4'h0;
    cfg_we       = 1'b0;
    cfg_ch       = 2'd0;
    cfg_div      = 16'd0;
    cfg_mode     = 1'b0;
    sync_restart = 1'b0;

    // Reset defaults: N=4 pulse on every channel
    tick(3);
    chk("rst_clk", 32'(clk_out), 32'h0);
    chk("rst_tc", 32'(tc_out), 32'h0);
    chk("rst_pend", 32'(cfg_pending), 32'h0);
    reset_n = 1'b1;
    en      = 4'hF;
    tick(3);
    chk("def_e3_tc", 32'(tc_out), 32'h0);
    tick(1);
    chk("def_e4_tc", 32'(tc_out), 32'hF);
    chk("def_e4_clk", 32'(clk_out), 32'hF);
    tick(1);
    chk("def_e5_clk", 32'(clk_out), 32'h0);
    tick(3);
    chk("def_e8_tc", 32'(tc_out), 32'hF);
    tick(4);
    chk("def_e12_tc", 32'(tc_out), 32'hF);
    chk("def_pend", 32'(cfg_pending), 32'h0);

    // Square, odd divisor on ch1, then restart (r counts edges after it)
    wr(2'd1, 16'd5, 1'b1);
    tick(1);
    cfg_we = 1'b0;
    chk("sq_pend", 32'(cfg_pending), 32'h2);
    sync_restart = 1'b1;
    tick(1);
    sync_restart = 1'b0;
    chk("rs_pend", 32'(cfg_pending), 32'h0);
    chk("rs_clk", 32'(clk_out), 32'h0);
    chk("rs_tc", 32'(tc_out), 32'h0);
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      chk($sformatf("sq_clk_r%0d", k), 32'(clk_out[1]),
          32'((k >= 5) && ((k % 5 == 0) || (k % 5 == 1))));
      chk($sformatf("sq_tc_r%0d", k), 32'(tc_out[1]),
          32'(k % 5 == 0));
    end

    // Mid-period reconfig of ch0: r=17 has counter=1
    tick(2);
    wr(2'd0, 16'd6, 1'b0);
    tick(1);
    cfg_we = 1'b0;
    chk("mid_pend_r18", 32'(cfg_pending[0]), 32'h1);
    chk("mid_tc_r18", 32'(tc_out[0]), 32'h0);
    tick(1);
    chk("mid_pend_r19", 32'(cfg_pending[0]), 32'h1);
    tick(1);
    chk("mid_wrap_r20", 32'(tc_out[0]), 32'h1);
    chk("mid_pend_r20", 32'(cfg_pending[0]), 32'h0);
    tick(5);
    chk("n6_tc_r25", 32'(tc_out[0]), 32'h0);
    tick(1);
    chk("n6_tc_r26", 32'(tc_out[0]), 32'h1);
    tick(6);
    chk("n6_tc_r32", 32'(tc_out[0]), 32'h1);

    // Write on the wrap edge: wrap applies older shadow (5), 3 stays pending
    tick(1);
    wr(2'd0, 16'd5, 1'b0);
    tick(1);
    cfg_we = 1'b0;
    chk("ww_pend_r34", 32'(cfg_pending[0]), 32'h1);
    tick(3);
    wr(2'd0, 16'd3, 1'b0);
    tick(1);
    cfg_we = 1'b0;
    chk("ww_tc_r38", 32'(tc_out[0]), 32'h1);
    chk("ww_pend_r38", 32'(cfg_pending[0]), 32'h1);
    tick(4);
    chk("n5_tc_r42", 32'(tc_out[0]), 32'h0);
    tick(1);
    chk("n5_tc_r43", 32'(tc_out[0]), 32'h1);
    chk("n5_pend_r43", 32'(cfg_pending[0]), 32'h0);
    tick(2);
    chk("n3_tc_r45", 32'(tc_out[0]), 32'h0);
    tick(1);
    chk("n3_tc_r46", 32'(tc_out[0]), 32'h1);
    tick(3);
    chk("n3_tc_r49", 32'(tc_out[0]), 32'h1);

    // Freeze ch2 at counter=2 for 7 edges
    tick(1);
    en = 4'b1011;
    for (int k = 0; k < 7; k++) begin
      tick(1);
      chk($sformatf("frz_clk_%0d", k), 32'(clk_out[2]), 32'h0);
      chk($sformatf("frz_tc_%0d", k), 32'(tc_out[2]), 32'h0);
    end
    en = 4'hF;
    tick(1);
    chk("frz_tc_r58", 32'(tc_out[2]), 32'h0);
    tick(1);
    chk("frz_tc_r59", 32'(tc_out[2]), 32'h1);

    // Divisor 0 on ch3 clamps to 2
    tick(1);
    chk("cl_tc_r60", 32'(tc_out[3]), 32'h1);
    wr(2'd3, 16'd0, 1'b0);
    tick(1);
    cfg_we = 1'b0;
    chk("cl_pend_r61", 32'(cfg_pending[3]), 32'h1);
    tick(3);
    chk("cl_tc_r64", 32'(tc_out[3]), 32'h1);
    chk("cl_pend_r64", 32'(cfg_pending[3]), 32'h0);
    tick(1);
    chk("cl_tc_r65", 32'(tc_out[3]), 32'h0);
    tick(1);
    chk("cl_tc_r66", 32'(tc_out[3]), 32'h1);
    tick(1);
    chk("cl_tc_r67", 32'(tc_out[3]), 32'h0);
    tick(1);
    chk("cl_tc_r68", 32'(tc_out[3]), 32'h1);

    // Restart alignment with N = 4/6/8/2 from a random phase
    wr(2'd0, 16'd4, 1'b0);
    tick(1);
    wr(2'd1, 16'd6, 1'b0);
    tick(1);
    wr(2'd2, 16'd8, 1'b0);
    tick(1);
    cfg_we = 1'b0;
    w = $urandom_range(0, 7);
    if (w > 0) tick(w);
    sync_restart = 1'b1;
    tick(1);
    sync_restart = 1'b0;
    chk("al_pend", 32'(cfg_pending), 32'h0);
    tick(12);
    chk("al_tc_12", 32'(tc_out), 32'hB);
    tick(11);
    chk("al_tc_23", 32'(tc_out), 32'h0);
    tick(1);
    chk("al_tc_24", 32'(tc_out), 32'hF);
    tick(24);
    chk("al_tc_48", 32'(tc_out), 32'hF);

    // Reset mid-period with a pending write
    tick(2);
    wr(2'd2, 16'd7, 1'b0);
    tick(1);
    cfg_we = 1'b0;
    chk("mr_pend_pre", 32'(cfg_pending), 32'h4);
    reset_n = 1'b0;
    tick(1);
    chk("mr_clk", 32'(clk_out), 32'h0);
    chk("mr_tc", 32'(tc_out), 32'h0);
    chk("mr_pend", 32'(cfg_pending), 32'h0);
    reset_n = 1'b1;
    tick(3);
    chk("mr_tc_e3", 32'(tc_out), 32'h0);
    tick(1);
    chk("mr_tc_e4", 32'(tc_out), 32'hF);
    chk("mr_clk_e4", 32'(clk_out), 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
